// File: rtl/flag_branch_pc_pkg.sv
// flag_branch_pc_pkg
//   Shared types and default widths for the flag-qualified PC sequencer.
//   state_e       : sequencer state (IDLE / RUN / DONE)
//   *_DEF         : default PC width, LUT index width and start address
package flag_branch_pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int PC_W_DEF     = 10;
    localparam int IDX_W_DEF    = 5;
    localparam int START_PC_DEF = 0;

endpackage

// File: rtl/flag_branch_pc_if.sv
// flag_branch_pc_if
//   Groups the control inputs and status outputs of flag_branch_pc.
//   master : driver side (control sources / observer of PC and status)
//   slave  : the sequencer itself
//   Inputs : start, stall, halt, jump_en, branch_en, flag_in, target_idx
//   Outputs: PC, running, done, taken, wrap_err
interface flag_branch_pc_if
    import flag_branch_pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
);
    logic             start;
    logic             stall;
    logic             halt;
    logic             jump_en;
    logic             branch_en;
    logic             flag_in;
    logic [IDX_W-1:0] target_idx;
    logic [PC_W-1:0]  PC;
    logic             running;
    logic             done;
    logic             taken;
    logic             wrap_err;

    modport master (
        output start, stall, halt, jump_en, branch_en, flag_in, target_idx,
        input  PC, running, done, taken, wrap_err
    );

    modport slave (
        input  start, stall, halt, jump_en, branch_en, flag_in, target_idx,
        output PC, running, done, taken, wrap_err
    );
endinterface

// File: rtl/flag_branch_pc_branch_lut.sv
// flag_branch_pc_branch_lut
//   Combinational branch-target ROM: target_idx_i -> target_o.
//   target_idx_i : LUT index (IDX_W bits)
//   target_o     : redirect address (PC_W bits)
//   Entries 0..3 are fixed landmarks; every other entry is index*8.
module flag_branch_pc_branch_lut
    import flag_branch_pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] target_idx_i,
    output logic [PC_W-1:0]  target_o
);

    always_comb begin
        target_o = PC_W'({target_idx_i, 3'b000});
        case (target_idx_i)
            IDX_W'(0): target_o = PC_W'(10'h000);
            IDX_W'(1): target_o = PC_W'(10'h040);
            IDX_W'(2): target_o = PC_W'(10'h100);
            // Top of a 10-bit space; used to exercise the wrap detector.
            IDX_W'(3): target_o = PC_W'(10'h3FF);
            default:   target_o = PC_W'({target_idx_i, 3'b000});
        endcase
    end

endmodule

// File: rtl/flag_branch_pc.sv
// flag_branch_pc
//   Program counter / branch sequencer fed by the one-cycle flag register.
//   CLK  : rising-edge clock
//   init : asynchronous active-high reset
//   bus  : control inputs (start, stall, halt, jump_en, branch_en, flag_in,
//          target_idx) and registered status (PC, running, done, taken,
//          wrap_err)
//   Priority in RUN: halt > stall > jump > flagged branch > increment.
module flag_branch_pc
    import flag_branch_pc_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int START_PC = START_PC_DEF
) (
    input  logic               CLK,
    input  logic               init,
    flag_branch_pc_if.slave    bus
);

    localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              flag_hold_q, flag_hold_d;
    logic              taken_q, taken_d;
    logic              wrap_err_q, wrap_err_d;
    logic [PC_W-1:0]   lut_target;

    flag_branch_pc_branch_lut #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_lut (
        .target_idx_i (bus.target_idx),
        .target_o     (lut_target)
    );

    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            state_q     <= IDLE;
            pc_q        <= START_ADDR;
            flag_hold_q <= 1'b0;
            taken_q     <= 1'b0;
            wrap_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flag_hold_q <= flag_hold_d;
            taken_q     <= taken_d;
            wrap_err_q  <= wrap_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        // Only a stalled RUN cycle keeps the captured flag alive.
        flag_hold_d = 1'b0;
        taken_d     = 1'b0;
        wrap_err_d  = wrap_err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                end
            end

            RUN: begin
                if (bus.halt) begin
                    state_d = DONE;
                end else if (bus.stall) begin
                    // The flag register self-clears, so remember a flag seen
                    // while stalled for the branch that follows the stall.
                    flag_hold_d = flag_hold_q | bus.flag_in;
                end else if (bus.jump_en) begin
                    pc_d    = lut_target;
                    taken_d = 1'b1;
                end else if (bus.branch_en && (bus.flag_in || flag_hold_q)) begin
                    pc_d    = lut_target;
                    taken_d = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                    if (pc_q == '1) begin
                        wrap_err_d = 1'b1;
                    end
                end
            end

            DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    pc_d       = START_ADDR;
                    wrap_err_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    assign bus.PC       = pc_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.taken    = taken_q;
    assign bus.wrap_err = wrap_err_q;

endmodule

// File: tb/tb_flag_branch_pc.sv
// tb_flag_branch_pc
//   Directed table-driven bench for flag_branch_pc, plus hand-written
//   sequences for asynchronous reset and restart corners.
module tb_flag_branch_pc;
    import flag_branch_pc_pkg::*;

    localparam int PC_W  = 10;
    localparam int IDX_W = 5;

    logic clk;
    logic init;
    int   checks;
    int   errors;

    flag_branch_pc_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

    flag_branch_pc #(
        .PC_W     (PC_W),
        .IDX_W    (IDX_W),
        .START_PC (0)
    ) dut (
        .CLK  (clk),
        .init (init),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             start, stall, halt, jmp, br, flag;
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  pc;
        logic             run, dn, tk, wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, sl, hl, jp, b, f,
                                input int idx, input int pc,
                                input logic r, d, t, w);
        vec_t v;
        v.start = st; v.stall = sl; v.halt = hl; v.jmp = jp; v.br = b; v.flag = f;
        v.idx = IDX_W'(idx); v.pc = PC_W'(pc);
        v.run = r; v.dn = d; v.tk = t; v.wrap = w;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pc, input logic r, d, t, w);
        chk({tag, ".PC"},       int'(bus.PC),       pc);
        chk({tag, ".running"},  int'(bus.running),  int'(r));
        chk({tag, ".done"},     int'(bus.done),     int'(d));
        chk({tag, ".taken"},    int'(bus.taken),    int'(t));
        chk({tag, ".wrap_err"}, int'(bus.wrap_err), int'(w));
    endtask

    task automatic drive(input logic st, sl, hl, jp, b, f, input int idx);
        bus.start = st; bus.stall = sl; bus.halt = hl;
        bus.jump_en = jp; bus.branch_en = b; bus.flag_in = f;
        bus.target_idx = IDX_W'(idx);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        init = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        //       st sl hl jp br fl idx  pc     run dn tk wr
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 2, 'h000, 0, 0, 0, 0)); // IDLE ignores all
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 'h000, 1, 0, 0, 0)); // start
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h003, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h004, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h005, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h040, 1, 0, 1, 0)); // branch taken
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h041, 1, 0, 0, 0)); // taken 1 cycle
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 'h042, 1, 0, 0, 0)); // flag=0: fall through
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 'h042, 1, 0, 0, 0)); // stall, capture flag
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 'h042, 1, 0, 0, 0)); // stall, flag gone
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 'h100, 1, 0, 1, 0)); // held flag branches
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 'h101, 1, 0, 0, 0)); // hold cleared
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 'h040, 1, 0, 1, 0)); // jump+branch flag0
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 2, 'h040, 0, 1, 0, 0)); // halt beats jump
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 2, 'h040, 0, 1, 0, 0)); // DONE ignores
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 3, 'h040, 0, 1, 0, 0)); // DONE frozen
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 'h000, 1, 0, 0, 0)); // start beats halt
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 3, 'h3FF, 1, 0, 1, 0)); // jump to top
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h000, 1, 0, 0, 1)); // wrap
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h001, 1, 0, 0, 1)); // sticky
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 'h001, 1, 0, 0, 1)); // stall captures
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h002, 1, 0, 0, 1)); // plain step clears hold
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 'h003, 1, 0, 0, 1)); // so not taken
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2, 'h003, 1, 0, 0, 1)); // stall beats jump
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 'h003, 0, 1, 0, 1)); // halt keeps wrap_err
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 'h000, 1, 0, 0, 0)); // restart clears wrap
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h001, 1, 0, 0, 0));

        // Reset state while init held.
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        tick();
        init = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stall, vecs[i].halt,
                  vecs[i].jmp, vecs[i].br, vecs[i].flag, int'(vecs[i].idx));
            tick();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].pc),
                    vecs[i].run, vecs[i].dn, vecs[i].tk, vecs[i].wrap);
        end

        // Async reset mid-cycle while taken and wrap_err are both set.
        drive(0, 0, 0, 1, 0, 0, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 2);
        tick();
        chk_all("pre_init", 'h100, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        init = 1'b1;
        #1;
        chk_all("async_init", 0, 0, 0, 0, 0);
        #1;
        init = 1'b0;
        // Waits in IDLE without start.
        tick();
        tick();
        chk_all("idle_wait", 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk_all("restart", 0, 1, 0, 0, 0);
        tick();
        chk_all("step_after_restart", 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
